mcast_dispatch: RTL and testbench
=================================

# mcast_dispatch

Sits between an input buffer (buffer_in) head and the five output arbiters of a MAZE node. It consumes the 5-bit route_req stored with each packet (N/W/S/E/B, possibly multi-hot for multicast or broadcast) and requests every marked output. It removes satisfied requests as grants arrive, and pops the buffer only when every copy has been accepted. It is the consumer and executor of the route request that the pre-buffer routing stage produces.

## Interface
Parameters:
- PKT_W, 32, width of the packet word carried from buffer head to outputs
- CNT_W, 16, width of the saturating packet and drop counters
- WDOG_CYC, 1024, number of SERVE cycles before the watchdog flags (used only with the watchdog option)

Ports:
- clk  in  1  single clock; all state is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- buf_valid  in  1  buffer head holds a valid packet
- buf_pkt  in  PKT_W  head packet word
- buf_route_req  in  5  head route mask; bit indices are DIR_N/W/S/E/B
- buf_pop  out  1  one-cycle pop strobe to the buffer
- out_req  out  5  registered request to each output arbiter
- out_pkt  out  PKT_W  latched packet word, stable while in SERVE
- grant  in  5  per-output grant; valid only for bits with out_req high
- pkt_cnt  out  CNT_W  packets completed with a non-zero mask (saturating)
- drop_cnt  out  CNT_W  packets popped with a zero mask (saturating)
- err_sticky  out  1  a grant arrived on a bit with out_req low
- wdog_flag  out  1  sticky watchdog flag; tied to 0 when the watchdog is compiled out

## Operation
- FSM states: IDLE, SERVE, POP.
- **IDLE**
  - If buf_valid is high, latch buf_pkt into out_pkt and buf_route_req into pending.
  - If the mask is non-zero, go to SERVE; if it is zero, go to POP and increment drop_cnt.
  - If buf_valid is low, stay in IDLE.
- **SERVE**
  - out_req = pending (registered).
  - Each cycle, pending <= pending & ~grant.
  - When (pending & ~grant) == 0, go to POP and increment pkt_cnt.
  - Any number of grant bits may arrive together. An all-ones mask granted in one cycle completes in that cycle.
- **POP**
  - buf_pop = 1 for exactly one cycle, then go to IDLE.
  - out_req is 0 in POP and IDLE.
- **Stray grants:** a grant bit where out_req is 0 is ignored and sets err_sticky. err_sticky clears only on reset.
- **Counters:** pkt_cnt and drop_cnt saturate at all-ones and do not wrap.
- **Packet contents:** out_pkt is never modified. Every output receives an identical copy.
- **Reset:**
  - Asserting rst_n low at any time, including mid-SERVE, forces IDLE asynchronously.
  - Pending is discarded and no pop is issued.
  - The buffer is reset by the same rst_n.

## Timing
- **Reset values:** out_req = 0, buf_pop = 0, out_pkt = 0, pkt_cnt = 0, drop_cnt = 0, err_sticky = 0, wdog_flag = 0, state = IDLE.
- **Fastest sequence**, with buf_valid sampled in IDLE at cycle T:
  - out_req asserted at T+1.
  - If the grant arrives at T+1, buf_pop is asserted at T+2.
  - IDLE at T+3 samples the next head.
  - Minimum period is 3 cycles per packet.
- **Zero mask:** buf_pop at T+1, IDLE at T+2.
- **Grant response:** a granted bit drops from out_req on the cycle after the grant. Arbiters must not grant a bit twice for one packet; the one-cycle deassert lag guarantees this.
- **buf_pkt and buf_route_req** are sampled only in IDLE. Changes on them outside IDLE are ignored.
- **Combinational paths:** buf_pop is registered. There is no combinational path from grant to any output.

## Configuration
- Macro: MCAST_DISPATCH_WDOG_EN.
- **Defined:**
  - A counter of width clog2(WDOG_CYC)+1 clears on entry to SERVE and increments each SERVE cycle.
  - On reaching WDOG_CYC, wdog_flag is set. It is sticky until reset.
  - Operation is otherwise unchanged: there is no forced pop.
- **Undefined:** the counter is absent and wdog_flag is constant 0.

## Structure
- Shared package maze_pkg holds:
  - the direction index constants DIR_N, DIR_W, DIR_S, DIR_E, DIR_B;
  - the state enum typedef disp_state_t {IDLE, SERVE, POP}.
- Bits are referenced by name, not by literal index.
- Sub-module sat_counter (parameter W; inputs clk, rst_n, inc; output cnt) is instantiated twice, for pkt_cnt and drop_cnt.
- The watchdog counter is inline.

## Test plan
- **Unicast:** route_req = 5'b00010 (DIR_E only) at T, grant[DIR_E] at T+1 -> out_req = 00010 at T+1, buf_pop at T+2, pkt_cnt = 1.
- **Staggered broadcast:** route_req = 11111, grants one bit per cycle in order B, E, S, W, N -> out_req steps 11111 -> ... -> 00000, single buf_pop after the fifth grant, out_pkt unchanged throughout.
- **Simultaneous grants:** route_req = 01110 fully granted in one cycle -> buf_pop the next cycle, no err_sticky.
- **Zero mask:** buf_valid with route_req = 0 -> buf_pop at T+1, drop_cnt = 1, out_req stays 0.
- **Stray grant and watchdog:** in SERVE with out_req = 00100, drive grant = 10000 -> err_sticky = 1, pending unchanged. With MCAST_DISPATCH_WDOG_EN and WDOG_CYC = 8, withhold grants -> wdog_flag = 1 after 8 SERVE cycles.
- **Reset mid-SERVE:** assert rst_n low during SERVE with pending = 00011 -> immediately out_req = 0, no buf_pop, all counters 0; after release, the next buf_valid is handled normally.

Source files
------------

// File: rtl/maze_pkg.sv
// maze_pkg: direction indices and dispatcher FSM state shared across the
// MAZE node. Route masks are 5 bits wide with N in the MSB and B in the LSB.
package maze_pkg;

   localparam int NUM_DIR = 5;

   localparam int DIR_N = 4;
   localparam int DIR_W = 3;
   localparam int DIR_S = 2;
   localparam int DIR_E = 1;
   localparam int DIR_B = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      POP   = 2'd2
   } disp_state_t;

endpackage : maze_pkg

// File: rtl/mcast_dispatch_if.sv
// mcast_dispatch_if: buffer-head and output-arbiter signals of the multicast
// dispatcher.
//
// Handshake semantics:
//   buffer side : buf_valid/buf_pkt/buf_route_req describe the head entry and
//                 stay stable until buf_pop; buf_pop is a one-cycle strobe,
//                 and the buffer advances on the clock edge that ends it.
//   arbiter side: out_req[d] is the request to output d; grant[d] is
//                 meaningful only while out_req[d] is high and means one copy
//                 was taken on that edge. out_req[d] drops the cycle after.
// The dispatcher uses the slave modport; the buffer/arbiter environment uses
// the master modport.
interface mcast_dispatch_if #(
   parameter int PKT_W = 32
);

   logic                         buf_valid;
   logic [PKT_W-1:0]             buf_pkt;
   logic [maze_pkg::NUM_DIR-1:0] buf_route_req;
   logic                         buf_pop;
   logic [maze_pkg::NUM_DIR-1:0] out_req;
   logic [PKT_W-1:0]             out_pkt;
   logic [maze_pkg::NUM_DIR-1:0] grant;

   modport slave (
      input  buf_valid,
      input  buf_pkt,
      input  buf_route_req,
      input  grant,
      output buf_pop,
      output out_req,
      output out_pkt
   );

   modport master (
      output buf_valid,
      output buf_pkt,
      output buf_route_req,
      output grant,
      input  buf_pop,
      input  out_req,
      input  out_pkt
   );

endinterface : mcast_dispatch_if

// File: rtl/mcast_dispatch_sat_counter.sv
// sat_counter: W-bit event counter that sticks at all-ones instead of
// wrapping. Cleared by the asynchronous active-low reset.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   // Count inc pulses, holding once all-ones is reached.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule : sat_counter

// File: rtl/mcast_dispatch.sv
// mcast_dispatch: takes the head packet of the input buffer, requests every
// output marked in its route mask, retires mask bits as grants arrive and
// pops the buffer once every copy is accepted. Zero-mask packets are popped
// and counted as drops.
//
// Optional feature: define MCAST_DISPATCH_WDOG_EN to build a SERVE-cycle
// watchdog that raises the sticky wdog_flag after WDOG_CYC cycles in SERVE.
// Without it wdog_flag is constant 0.
module mcast_dispatch
   import maze_pkg::*;
#(
   parameter int PKT_W    = 32,
   parameter int CNT_W    = 16,
   parameter int WDOG_CYC = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mcast_dispatch_if.slave      bus,
   output logic [CNT_W-1:0]     pkt_cnt,
   output logic [CNT_W-1:0]     drop_cnt,
   output logic                 err_sticky,
   output logic                 wdog_flag,
   output disp_state_t          dbg_state
);

   disp_state_t        state;
   disp_state_t        state_nxt;
   logic [NUM_DIR-1:0] pending;
   logic [NUM_DIR-1:0] pending_nxt;
   logic [NUM_DIR-1:0] remain;
   logic               latch_en;
   logic               pkt_inc;
   logic               drop_inc;

   // Requests still outstanding after this cycle's grants. Stray grant bits
   // are outside pending, so they cannot change it.
   assign remain = pending & ~bus.grant;

   // Outputs decode registered state only: no combinational grant path.
   assign bus.out_req = (state == SERVE) ? pending : '0;
   assign bus.buf_pop = (state == POP);
   assign dbg_state   = state;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, pending update and counter strobes.
   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      latch_en    = 1'b0;
      pkt_inc     = 1'b0;
      drop_inc    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.buf_valid) begin
               latch_en    = 1'b1;
               pending_nxt = bus.buf_route_req;
               if (|bus.buf_route_req) begin
                  state_nxt = SERVE;
               end else begin
                  state_nxt = POP;
                  drop_inc  = 1'b1;
               end
            end
         end
         SERVE: begin
            pending_nxt = remain;
            if (remain == '0) begin
               state_nxt = POP;
               pkt_inc   = 1'b1;
            end
         end
         POP: begin
            pending_nxt = '0;
            state_nxt   = IDLE;
         end
         default: begin
            pending_nxt = '0;
            state_nxt   = IDLE;
         end
      endcase
   end

   // Pending request mask and the packet copy presented to every output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending     <= '0;
         bus.out_pkt <= '0;
      end else begin
         pending <= pending_nxt;
         if (latch_en) begin
            bus.out_pkt <= bus.buf_pkt;
         end
      end
   end

   // Any grant on a bit that is not currently requested is a protocol error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sticky <= 1'b0;
      end else if (|(bus.grant & ~bus.out_req)) begin
         err_sticky <= 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_pkt_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (pkt_inc),
      .cnt   (pkt_cnt)
   );

   sat_counter #(.W(CNT_W)) u_drop_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (drop_inc),
      .cnt   (drop_cnt)
   );

`ifdef MCAST_DISPATCH_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYC) + 1;
   localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(WDOG_CYC);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);

   logic [WDOG_W-1:0] wdog_cnt;
   logic              wdog_q;

   // Count SERVE cycles of the current packet; restart on SERVE entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_cnt <= '0;
      end else if ((state == IDLE) && (state_nxt == SERVE)) begin
         wdog_cnt <= '0;
      end else if ((state == SERVE) && (wdog_cnt != WDOG_MAX)) begin
         wdog_cnt <= wdog_cnt + 1'b1;
      end
   end

   // Flag sets on the edge where the count reaches WDOG_CYC; no forced pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdog_q <= 1'b0;
      end else if ((state == SERVE) && (wdog_cnt == WDOG_LAST)) begin
         wdog_q <= 1'b1;
      end
   end

   assign wdog_flag = wdog_q;
`else
   assign wdog_flag = 1'b0;
`endif

endmodule : mcast_dispatch

// File: tb/tb_mcast_dispatch.sv
// tb_mcast_dispatch: directed vectors for mcast_dispatch with hand-computed
// expectations; popped packet words are checked against an expected queue.
module tb_mcast_dispatch;
   import maze_pkg::*;

   localparam int PKT_W = 32;
   localparam int CNT_W = 16;

   logic             clk;
   logic             rst_n;
   logic [CNT_W-1:0] pkt_cnt;
   logic [CNT_W-1:0] drop_cnt;
   logic             err_sticky;
   logic             wdog_flag;
   disp_state_t      dbg_state;

   int n_vec = 0;
   int n_bad = 0;
   logic [PKT_W-1:0] exp_q[$];

   mcast_dispatch_if #(.PKT_W(PKT_W)) bus ();

   mcast_dispatch #(
      .PKT_W    (PKT_W),
      .CNT_W    (CNT_W),
      .WDOG_CYC (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave),
      .pkt_cnt    (pkt_cnt),
      .drop_cnt   (drop_cnt),
      .err_sticky (err_sticky),
      .wdog_flag  (wdog_flag),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a head entry for one sampling edge, then withdraw it.
   task automatic launch(input logic [PKT_W-1:0] pkt, input logic [4:0] mask);
      bus.buf_valid     = 1'b1;
      bus.buf_pkt       = pkt;
      bus.buf_route_req = mask;
      tick();
      bus.buf_valid     = 1'b0;
   endtask

   // ---------------- scoreboard ----------------
   // Every pop must release the oldest expected packet word.
   always @(negedge clk) begin
      if (rst_n && bus.buf_pop) begin
         if (exp_q.size() == 0) begin
            check_val("pop_unexpected", 32'd1, 32'd0);
         end else begin
            check_val("pop_pkt", bus.out_pkt, exp_q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int         bc_dir [5];
      logic [4:0] bc_exp [4];
      bc_dir = '{DIR_B, DIR_E, DIR_S, DIR_W, DIR_N};
      bc_exp = '{5'b11110, 5'b11100, 5'b11000, 5'b10000};

      rst_n             = 1'b0;
      bus.buf_valid     = 1'b0;
      bus.buf_pkt       = '0;
      bus.buf_route_req = '0;
      bus.grant         = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset values
      check_val("rst_out_req", 32'(bus.out_req), 32'h0);
      check_val("rst_pop", 32'(bus.buf_pop), 32'h0);
      check_val("rst_out_pkt", bus.out_pkt, 32'h0);
      check_val("rst_pkt_cnt", 32'(pkt_cnt), 32'h0);
      check_val("rst_drop_cnt", 32'(drop_cnt), 32'h0);
      check_val("rst_err", 32'(err_sticky), 32'h0);
      check_val("rst_wdog", 32'(wdog_flag), 32'h0);
      check_val("rst_state", 32'(dbg_state), 32'(IDLE));
      rst_n = 1'b1;
      tick();

      // Unicast east
      exp_q.push_back(32'h1111_0001);
      launch(32'h1111_0001, 5'b00010);
      check_val("uni_req", 32'(bus.out_req), 32'h02);
      check_val("uni_state", 32'(dbg_state), 32'(SERVE));
      bus.grant[DIR_E] = 1'b1;
      tick();
      bus.grant = '0;
      check_val("uni_pop", 32'(bus.buf_pop), 32'h1);
      check_val("uni_req_off", 32'(bus.out_req), 32'h0);
      check_val("uni_pkt_cnt", 32'(pkt_cnt), 32'd1);
      tick();
      check_val("uni_pop_end", 32'(bus.buf_pop), 32'h0);
      check_val("uni_idle", 32'(dbg_state), 32'(IDLE));

      // Staggered broadcast, grants B,E,S,W,N; head changes are ignored
      exp_q.push_back(32'hA5A5_5A5A);
      launch(32'hA5A5_5A5A, 5'b11111);
      bus.buf_pkt       = 32'hDEAD_BEEF;
      bus.buf_route_req = 5'b00001;
      check_val("bc_req0", 32'(bus.out_req), 32'h1F);
      for (int i = 0; i < 5; i++) begin
         bus.grant            = '0;
         bus.grant[bc_dir[i]] = 1'b1;
         tick();
         if (i < 4) begin
            check_val("bc_req", 32'(bus.out_req), 32'(bc_exp[i]));
            check_val("bc_no_pop", 32'(bus.buf_pop), 32'h0);
            check_val("bc_pkt_hold", bus.out_pkt, 32'hA5A5_5A5A);
         end else begin
            check_val("bc_pop", 32'(bus.buf_pop), 32'h1);
            check_val("bc_req_off", 32'(bus.out_req), 32'h0);
            check_val("bc_pkt_cnt", 32'(pkt_cnt), 32'd2);
         end
      end
      bus.grant = '0;
      tick();
      check_val("bc_pop_end", 32'(bus.buf_pop), 32'h0);

      // Simultaneous grants on W,S,E
      exp_q.push_back(32'h0BAD_F00D);
      launch(32'h0BAD_F00D, 5'b01110);
      check_val("sim_req", 32'(bus.out_req), 32'h0E);
      bus.grant = 5'b01110;
      tick();
      bus.grant = '0;
      check_val("sim_pop", 32'(bus.buf_pop), 32'h1);
      check_val("sim_pkt_cnt", 32'(pkt_cnt), 32'd3);
      check_val("sim_err", 32'(err_sticky), 32'h0);
      tick();

      // Zero mask drop
      exp_q.push_back(32'h0000_D809);
      launch(32'h0000_D809, 5'b00000);
      check_val("zero_pop", 32'(bus.buf_pop), 32'h1);
      check_val("zero_req", 32'(bus.out_req), 32'h0);
      check_val("zero_drop_cnt", 32'(drop_cnt), 32'd1);
      check_val("zero_pkt_cnt", 32'(pkt_cnt), 32'd3);
      tick();
      check_val("zero_idle", 32'(dbg_state), 32'(IDLE));
      check_val("zero_pop_end", 32'(bus.buf_pop), 32'h0);

      // Stray grant on N while only S is requested, then withheld grants
      exp_q.push_back(32'h5757_0004);
      launch(32'h5757_0004, 5'b00100);
      check_val("stray_req", 32'(bus.out_req), 32'h04);
      check_val("stray_err_pre", 32'(err_sticky), 32'h0);
      bus.grant[DIR_N] = 1'b1;
      tick();
      bus.grant = '0;
      check_val("stray_err", 32'(err_sticky), 32'h1);
      check_val("stray_req_hold", 32'(bus.out_req), 32'h04);
      check_val("stray_no_pop", 32'(bus.buf_pop), 32'h0);
      repeat (3) tick();
      check_val("wdog_early", 32'(wdog_flag), 32'h0);
      repeat (6) tick();
`ifdef MCAST_DISPATCH_WDOG_EN
      check_val("wdog_set", 32'(wdog_flag), 32'h1);
`else
      check_val("wdog_off", 32'(wdog_flag), 32'h0);
`endif
      check_val("wdog_still_serve", 32'(dbg_state), 32'(SERVE));
      bus.grant[DIR_S] = 1'b1;
      tick();
      bus.grant = '0;
      check_val("stray_pop", 32'(bus.buf_pop), 32'h1);
      check_val("stray_pkt_cnt", 32'(pkt_cnt), 32'd4);
      tick();

      // Reset mid-SERVE with pending W? no: E and B
      launch(32'hCAFE_0003, 5'b00011);
      check_val("mid_req", 32'(bus.out_req), 32'h03);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_req", 32'(bus.out_req), 32'h0);
      check_val("mid_rst_pop", 32'(bus.buf_pop), 32'h0);
      check_val("mid_rst_state", 32'(dbg_state), 32'(IDLE));
      check_val("mid_rst_pkt_cnt", 32'(pkt_cnt), 32'h0);
      check_val("mid_rst_drop_cnt", 32'(drop_cnt), 32'h0);
      check_val("mid_rst_err", 32'(err_sticky), 32'h0);
      check_val("mid_rst_wdog", 32'(wdog_flag), 32'h0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Normal unicast west after reset release
      exp_q.push_back(32'h7E57_0008);
      launch(32'h7E57_0008, 5'b01000);
      check_val("post_req", 32'(bus.out_req), 32'h08);
      bus.grant[DIR_W] = 1'b1;
      tick();
      bus.grant = '0;
      check_val("post_pop", 32'(bus.buf_pop), 32'h1);
      check_val("post_pkt_cnt", 32'(pkt_cnt), 32'd1);
      tick();
      check_val("post_idle", 32'(dbg_state), 32'(IDLE));

      // Final report
      check_val("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_mcast_dispatch
